// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, grant ids and
// the round-robin winner selection used when the arbiter leaves IDLE.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // On contention the master that did not win last time gets the bus.
  function automatic logic pick_winner(
    input logic ifu_valid,
    input logic lsu_valid,
    input logic last_grant
  );
    if (ifu_valid && lsu_valid) begin
      return ~last_grant;
    end else if (lsu_valid) begin
      return GNT_LSU;
    end else begin
      return GNT_IFU;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Watchdog up-counter: synchronous clear, count enable, saturates at TIMEOUT-1
// and flags that terminal value so the arbiter can give up on the slave.
module bus_wait_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  output logic [$clog2(TIMEOUT)-1:0] count,
  output logic                       terminal
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  assign terminal = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single memory port: IFU (read-only) and LSU
// (read/write) share one slave, one locked transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifu_req_valid,
  output logic                       ifu_req_ready,
  input  logic [ADDR_W-1:0]          ifu_addr,
  output logic                       ifu_rsp_valid,
  input  logic                       ifu_rsp_ready,
  output logic [DATA_W-1:0]          ifu_rdata,
  output logic                       ifu_rsp_err,
  input  logic                       lsu_req_valid,
  output logic                       lsu_req_ready,
  input  logic [ADDR_W-1:0]          lsu_addr,
  input  logic [DATA_W-1:0]          lsu_wdata,
  input  logic                       lsu_wen,
  input  logic [DATA_W/8-1:0]        lsu_wstrb,
  output logic                       lsu_rsp_valid,
  input  logic                       lsu_rsp_ready,
  output logic [DATA_W-1:0]          lsu_rdata,
  output logic                       lsu_rsp_err,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wen,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  input  logic                       mem_rsp_valid,
  output logic                       mem_rsp_ready,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rsp_err,
  output logic                       bus_err,
  output state_t                     dbg_state,
  output logic [$clog2(TIMEOUT)-1:0] dbg_wait_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a source holds valid and payload stable until that edge, and
  // valid never depends on ready.

  localparam int CW = $clog2(TIMEOUT);

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              grant_next;
  logic              last_grant;
  logic              last_grant_next;
  logic              bus_err_next;
  logic              winner;

  logic              g_req_valid;
  logic              g_rsp_ready;
  logic              g_req_ready;
  logic              g_rsp_valid;
  logic              g_rsp_err;
  logic [DATA_W-1:0] g_rdata;

  logic [CW-1:0]     wait_count;
  logic              wait_done;
  logic              wait_clear;
  logic              wait_en;

  assign g_req_valid = (grant == GNT_LSU) ? lsu_req_valid : ifu_req_valid;
  assign g_rsp_ready = (grant == GNT_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
  assign winner      = pick_winner(ifu_req_valid, lsu_req_valid, last_grant);

  // Restart the watchdog whenever a new wait phase begins.
  assign wait_clear = (state_next != state) &&
                      ((state_next == ST_REQ) || (state_next == ST_RSP));

  bus_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .enable   (wait_en),
    .count    (wait_count),
    .terminal (wait_done)
  );

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    bus_err_next    = bus_err;
    wait_en         = 1'b0;
    mem_req_valid   = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_wen         = 1'b0;
    mem_wstrb       = '0;
    mem_rsp_ready   = 1'b1;
    g_req_ready     = 1'b0;
    g_rsp_valid     = 1'b0;
    g_rsp_err       = 1'b0;
    g_rdata         = '0;

    case (state)
      ST_IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          grant_next      = winner;
          last_grant_next = winner;
          state_next      = ST_REQ;
        end
        if (mem_rsp_valid) begin
          bus_err_next = 1'b1;
        end
      end

      ST_REQ: begin
        mem_req_valid = g_req_valid;
        g_req_ready   = mem_req_ready;
        if (grant == GNT_LSU) begin
          mem_addr  = lsu_addr;
          mem_wdata = lsu_wdata;
          mem_wen   = lsu_wen;
          mem_wstrb = lsu_wstrb;
        end else begin
          mem_addr  = ifu_addr;
        end
        if (!g_req_valid) begin
          state_next = ST_IDLE;
        end else if (mem_req_ready) begin
          state_next = ST_RSP;
        end else begin
          wait_en = 1'b1;
          if (wait_done) begin
            state_next   = ST_ERR;
            bus_err_next = 1'b1;
          end
        end
        if (mem_rsp_valid) begin
          bus_err_next = 1'b1;
        end
      end

      ST_RSP: begin
        mem_rsp_ready = g_rsp_ready;
        g_rsp_valid   = mem_rsp_valid;
        if (mem_rsp_valid) begin
          g_rdata   = mem_rdata;
          g_rsp_err = mem_rsp_err;
          if (g_rsp_ready) begin
            state_next = ST_IDLE;
          end
        end else begin
          // Only a silent slave counts; master backpressure never times out.
          wait_en = 1'b1;
          if (wait_done) begin
            state_next   = ST_ERR;
            bus_err_next = 1'b1;
          end
        end
      end

      ST_ERR: begin
        g_rsp_valid = 1'b1;
        g_rsp_err   = 1'b1;
        if (g_rsp_ready) begin
          state_next = ST_IDLE;
        end
        if (mem_rsp_valid) begin
          bus_err_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= GNT_IFU;
      last_grant <= GNT_IFU;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      bus_err    <= bus_err_next;
    end
  end

  // Non-granted master sees an idle port: no ready, no valid, zero data.
  assign ifu_req_ready = (grant == GNT_IFU) && g_req_ready;
  assign lsu_req_ready = (grant == GNT_LSU) && g_req_ready;
  assign ifu_rsp_valid = (grant == GNT_IFU) && g_rsp_valid;
  assign lsu_rsp_valid = (grant == GNT_LSU) && g_rsp_valid;
  assign ifu_rsp_err   = (grant == GNT_IFU) && g_rsp_err;
  assign lsu_rsp_err   = (grant == GNT_LSU) && g_rsp_err;
  assign ifu_rdata     = (grant == GNT_IFU) ? g_rdata : '0;
  assign lsu_rdata     = (grant == GNT_LSU) ? g_rdata : '0;

  assign dbg_state      = state;
  assign dbg_wait_count = wait_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural slave and per-master
// scoreboards for request payloads and responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SW      = DATA_W / 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(TIMEOUT);
  localparam int MW      = ADDR_W + DATA_W + 1 + SW;
  localparam logic [ADDR_W-1:0] ERR_ADDR = 32'hbad0_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ifu_req_valid = 1'b0;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr = '0;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready = 1'b1;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rsp_err;
  logic              lsu_req_valid = 1'b0;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr = '0;
  logic [DATA_W-1:0] lsu_wdata = '0;
  logic              lsu_wen = 1'b0;
  logic [SW-1:0]     lsu_wstrb = '0;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready = 1'b1;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rsp_err;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [SW-1:0]     mem_wstrb;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rsp_err;
  logic              bus_err;
  state_t            dbg_state;
  logic [CW-1:0]     dbg_wait_count;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_ready  (ifu_rsp_ready),
    .ifu_rdata      (ifu_rdata),
    .ifu_rsp_err    (ifu_rsp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wen        (lsu_wen),
    .lsu_wstrb      (lsu_wstrb),
    .lsu_rsp_valid  (lsu_rsp_valid),
    .lsu_rsp_ready  (lsu_rsp_ready),
    .lsu_rdata      (lsu_rdata),
    .lsu_rsp_err    (lsu_rsp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wen        (mem_wen),
    .mem_wstrb      (mem_wstrb),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rdata      (mem_rdata),
    .mem_rsp_err    (mem_rsp_err),
    .bus_err        (bus_err),
    .dbg_state      (dbg_state),
    .dbg_wait_count (dbg_wait_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9bdf);
  endfunction

  // ---------------- behavioural slave ----------------
  logic              slave_auto     = 1'b1;
  logic              slave_hang     = 1'b0;
  logic              auto_rsp_valid = 1'b0;
  logic [DATA_W-1:0] auto_rdata     = '0;
  logic              auto_rsp_err   = 1'b0;
  logic              man_rsp_valid  = 1'b0;
  logic [DATA_W-1:0] man_rdata      = '0;

  assign mem_rsp_valid = slave_auto ? auto_rsp_valid : man_rsp_valid;
  assign mem_rdata     = slave_auto ? auto_rdata : man_rdata;
  assign mem_rsp_err   = slave_auto ? auto_rsp_err : 1'b0;

  always begin : slave_proc
    logic              s_hs_req;
    logic              s_hs_rsp;
    logic [DATA_W-1:0] s_rd;
    logic              s_re;
    @(negedge clk);
    s_hs_rsp = slave_auto && auto_rsp_valid && mem_rsp_ready;
    s_hs_req = slave_auto && mem_req_valid && mem_req_ready && !slave_hang;
    s_rd     = mem_wen ? '0 : mem_word(mem_addr);
    s_re     = (mem_addr == ERR_ADDR);
    @(posedge clk);
    #1;
    if (s_hs_rsp) begin
      auto_rsp_valid = 1'b0;
      auto_rdata     = '0;
      auto_rsp_err   = 1'b0;
    end
    if (s_hs_req) begin
      auto_rsp_valid = 1'b1;
      auto_rdata     = s_rd;
      auto_rsp_err   = s_re;
    end
  end

  // ---------------- scoreboard ----------------
  logic [MW-1:0]   ifu_mem_q[$];
  logic [MW-1:0]   lsu_mem_q[$];
  logic [DATA_W:0] ifu_exp_q[$];
  logic [DATA_W:0] lsu_exp_q[$];
  logic            grant_log[$];

  always @(negedge clk) begin : monitor
    logic [MW-1:0]   m;
    logic [DATA_W:0] e;
    if (!rst) begin
      check("one_req_ready", 80'(ifu_req_ready & lsu_req_ready), 80'(0));
      if (mem_req_valid && mem_req_ready) begin
        grant_log.push_back(lsu_req_ready);
        if (lsu_req_ready) begin
          check("lsu_req_pending", 80'(lsu_mem_q.size() != 0), 80'(1));
          if (lsu_mem_q.size() != 0) begin
            m = lsu_mem_q.pop_front();
            check("lsu_mem_payload", 80'({mem_addr, mem_wdata, mem_wen, mem_wstrb}), 80'(m));
          end
        end else begin
          check("ifu_req_pending", 80'(ifu_mem_q.size() != 0), 80'(1));
          if (ifu_mem_q.size() != 0) begin
            m = ifu_mem_q.pop_front();
            check("ifu_mem_payload", 80'({mem_addr, mem_wdata, mem_wen, mem_wstrb}), 80'(m));
          end
        end
      end
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        check("ifu_rsp_pending", 80'(ifu_exp_q.size() != 0), 80'(1));
        if (ifu_exp_q.size() != 0) begin
          e = ifu_exp_q.pop_front();
          check("ifu_rsp_data", 80'({ifu_rsp_err, ifu_rdata}), 80'(e));
        end
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        check("lsu_rsp_pending", 80'(lsu_exp_q.size() != 0), 80'(1));
        if (lsu_exp_q.size() != 0) begin
          e = lsu_exp_q.pop_front();
          check("lsu_rsp_data", 80'({lsu_rsp_err, lsu_rdata}), 80'(e));
        end
      end
      if (!ifu_rsp_valid) check("ifu_rsp_quiet", 80'({ifu_rsp_err, ifu_rdata}), 80'(0));
      if (!lsu_rsp_valid) check("lsu_rsp_quiet", 80'({lsu_rsp_err, lsu_rdata}), 80'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ifu_issue(input logic [ADDR_W-1:0] a, input bit expect_rsp);
    int waited = 0;
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    ifu_mem_q.push_back({a, DATA_W'(0), 1'b0, SW'(0)});
    if (expect_rsp) ifu_exp_q.push_back({1'b0, mem_word(a)});
    forever begin
      @(negedge clk);
      if (ifu_req_ready) break;
      waited++;
      if (waited > 100) begin
        check("ifu_req_handshake", 80'(ifu_req_ready), 80'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
  endtask

  task automatic lsu_issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input logic wen, input logic [SW-1:0] ws, input bit expect_rsp);
    int waited = 0;
    lsu_req_valid = 1'b1;
    lsu_addr      = a;
    lsu_wdata     = wd;
    lsu_wen       = wen;
    lsu_wstrb     = ws;
    lsu_mem_q.push_back({a, wd, wen, ws});
    if (expect_rsp) lsu_exp_q.push_back({a == ERR_ADDR, wen ? DATA_W'(0) : mem_word(a)});
    forever begin
      @(negedge clk);
      if (lsu_req_ready) break;
      waited++;
      if (waited > 100) begin
        check("lsu_req_handshake", 80'(lsu_req_ready), 80'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wen       = 1'b0;
    lsu_wstrb     = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ifu_exp_q.size() != 0 || lsu_exp_q.size() != 0 || dbg_state != ST_IDLE) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_state", 80'(dbg_state), 80'(ST_IDLE));
    check("drain_rsp_q", 80'(ifu_exp_q.size() + lsu_exp_q.size()), 80'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int cnt;
    logic [2:0] order;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_state", 80'(dbg_state), 80'(ST_IDLE));
    check("rst_bus_err", 80'(bus_err), 80'(0));
    check("rst_wait_count", 80'(dbg_wait_count), 80'(0));
    check("rst_mem_rsp_ready", 80'(mem_rsp_ready), 80'(1));
    check("rst_req_ready", 80'({ifu_req_ready, lsu_req_ready}), 80'(0));
    check("rst_rsp_valid", 80'({ifu_rsp_valid, lsu_rsp_valid}), 80'(0));
    check("rst_mem_req", 80'({mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb}), 80'(0));
    step();
    rst = 1'b0;

    // Contention from reset: LSU, then IFU, then LSU's second request
    fork
      ifu_issue(32'h8000_0010, 1'b1);
      begin
        lsu_issue(32'h0000_2000, 32'h0, 1'b0, 4'h0, 1'b1);
        lsu_issue(32'h0000_2004, 32'hcafe_f00d, 1'b1, 4'h3, 1'b1);
      end
    join
    drain();
    check("arb_count", 80'(grant_log.size()), 80'(3));
    order = '0;
    for (int i = 0; i < 3 && i < grant_log.size(); i++) order[2-i] = grant_log[i];
    check("arb_order", 80'(order), 80'(3'b101));
    grant_log.delete();

    // IFU read with cycle-exact latency
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    ifu_mem_q.push_back({32'h8000_0000, DATA_W'(0), 1'b0, SW'(0)});
    ifu_exp_q.push_back({1'b0, 32'h0000_0413});
    @(negedge clk);
    check("ifu_t0_state", 80'(dbg_state), 80'(ST_IDLE));
    check("ifu_t0_mem_req_valid", 80'(mem_req_valid), 80'(0));
    step();
    @(negedge clk);
    check("ifu_t1_state", 80'(dbg_state), 80'(ST_REQ));
    check("ifu_t1_req", 80'({mem_req_valid, ifu_req_ready, lsu_req_ready}), 80'(3'b110));
    step();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    @(negedge clk);
    check("ifu_t2_rsp", 80'({ifu_rsp_valid, ifu_rsp_err, ifu_rdata}), 80'({2'b10, 32'h0000_0413}));
    check("ifu_t2_lsu_quiet", 80'({lsu_rsp_valid, lsu_req_ready, lsu_rdata}), 80'(0));
    step();
    @(negedge clk);
    check("ifu_t3_state", 80'(dbg_state), 80'(ST_IDLE));
    check("ifu_t3_rsp_valid", 80'(ifu_rsp_valid), 80'(0));
    step();

    // LSU store, then a load that the slave flags as an error
    lsu_issue(32'ha000_03f8, 32'h0000_0041, 1'b1, 4'hf, 1'b1);
    drain();
    lsu_issue(ERR_ADDR, 32'h0, 1'b0, 4'h0, 1'b1);
    drain();
    check("slave_err_no_bus_err", 80'(bus_err), 80'(0));

    // Abort: IFU drops its request before the slave accepts it
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    step();
    @(negedge clk);
    check("abort_req_state", 80'(dbg_state), 80'(ST_REQ));
    check("abort_req", 80'({mem_req_valid, ifu_req_ready}), 80'(2'b10));
    step();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    @(negedge clk);
    check("abort_drop_valid", 80'(mem_req_valid), 80'(0));
    step();
    @(negedge clk);
    check("abort_idle", 80'(dbg_state), 80'(ST_IDLE));
    step();
    mem_req_ready = 1'b1;

    // Master backpressure longer than TIMEOUT must not trip the watchdog
    ifu_rsp_ready = 1'b0;
    ifu_issue(32'h8000_0020, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dbg_state == ST_RSP && ifu_rsp_valid) cnt++;
    end
    check("bp_cycles_in_rsp", 80'(cnt), 80'(20));
    check("bp_wait_count", 80'(dbg_wait_count), 80'(0));
    step();
    ifu_rsp_ready = 1'b1;
    drain();
    check("bp_no_bus_err", 80'(bus_err), 80'(0));

    // Timeout: slave accepts but never answers
    slave_hang = 1'b1;
    lsu_issue(32'h0000_1000, 32'h0, 1'b0, 4'h0, 1'b0);
    lsu_exp_q.push_back({1'b1, DATA_W'(0)});
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lsu_rsp_valid) break;
      if (dbg_state == ST_RSP) cnt++;
    end
    check("to_wait_cycles", 80'(cnt), 80'(TIMEOUT));
    check("to_state", 80'(dbg_state), 80'(ST_ERR));
    check("to_rsp", 80'({lsu_rsp_valid, lsu_rsp_err, lsu_rdata}), 80'({2'b11, 32'h0}));
    check("to_bus_err", 80'(bus_err), 80'(1));
    step();
    @(negedge clk);
    check("to_back_idle", 80'(dbg_state), 80'(ST_IDLE));
    step();

    // Late response after the timeout is dropped
    slave_hang    = 1'b0;
    slave_auto    = 1'b0;
    man_rsp_valid = 1'b1;
    man_rdata     = 32'h1234_5678;
    @(negedge clk);
    check("late_no_rsp", 80'({ifu_rsp_valid, lsu_rsp_valid}), 80'(0));
    check("late_mem_rsp_ready", 80'(mem_rsp_ready), 80'(1));
    step();
    man_rsp_valid = 1'b0;
    man_rdata     = '0;
    @(negedge clk);
    check("late_state", 80'(dbg_state), 80'(ST_IDLE));
    check("late_bus_err_sticky", 80'(bus_err), 80'(1));
    step();

    // Reset while waiting in RSP; later slave response is stray
    ifu_issue(32'h8000_0030, 1'b0);
    @(negedge clk);
    check("rr_in_rsp", 80'(dbg_state), 80'(ST_RSP));
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rr_state", 80'(dbg_state), 80'(ST_IDLE));
    check("rr_outputs", 80'({ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready, mem_req_valid}), 80'(0));
    check("rr_bus_err_cleared", 80'(bus_err), 80'(0));
    step();
    man_rsp_valid = 1'b1;
    step();
    @(negedge clk);
    check("rr_stray_in_reset", 80'(bus_err), 80'(0));
    step();
    rst = 1'b0;
    step();
    man_rsp_valid = 1'b0;
    @(negedge clk);
    check("rr_stray_after_reset", 80'(bus_err), 80'(1));
    check("rr_idle", 80'(dbg_state), 80'(ST_IDLE));
    step();

    // Normal service resumes after reset
    slave_auto = 1'b1;
    ifu_issue(32'h8000_0000, 1'b1);
    drain();
    check("final_mem_q", 80'(ifu_mem_q.size() + lsu_mem_q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d assertions, %0d failures)", n_checks, n_fails);
    $fatal(1, "time limit");
  end

endmodule
